// File: rtl/lcd_bus_arbiter.sv
// Dual-chip 128x64 graphic LCD bus owner: power-on init, two-client round-robin
// byte writes, and per-chip page/column caching to skip redundant address commands.
module lcd_bus_arbiter #(
  parameter logic [5:0] START_LINE = 6'd0,
  parameter bit         ADDR_CACHE = 1'b1
) (
  input  logic       LCD_CLK,
  input  logic       RESETN,
  input  logic       REQ0_VALID,
  output logic       REQ0_READY,
  input  logic [2:0] REQ0_PAGE,
  input  logic [6:0] REQ0_COL,
  input  logic [7:0] REQ0_DATA,
  input  logic       REQ1_VALID,
  output logic       REQ1_READY,
  input  logic [2:0] REQ1_PAGE,
  input  logic [6:0] REQ1_COL,
  input  logic [7:0] REQ1_DATA,
  output logic       BUSY,
  output logic [7:0] LCD_DATA,
  output logic       LCD_ENABLE,
  output logic       LCD_RW,
  output logic       LCD_DI,
  output logic       LCD_CS1,
  output logic       LCD_CS2,
  output logic       LCD_RSTN
);

  typedef enum logic [2:0] {INIT_ON, INIT_LINE, IDLE, SET_PAGE, SET_COL, WRITE} state_t;

  state_t            state, state_nxt;
  logic              last;
  logic [2:0]        pg_q;
  logic [6:0]        col_q;
  logic [7:0]        dat_q;
  logic              ncol_q;
  logic [1:0]        c_vld;
  logic [1:0][2:0]   c_pg;
  logic [1:0][5:0]   c_col;
  logic              enable;

  logic              gnt0, gnt1, accept, chip;
  logic [2:0]        g_pg;
  logic [6:0]        g_col;
  logic [7:0]        g_dat;
  logic              need_pg, need_col;
  logic              en_d, di_d, cs1_d, cs2_d;
  logic [7:0]        data_d;

  // On a tie, grant the client that did not win last time.
  always_comb begin
    gnt0   = REQ0_VALID && (!REQ1_VALID || last);
    gnt1   = REQ1_VALID && (!REQ0_VALID || !last);
    g_pg   = gnt1 ? REQ1_PAGE : REQ0_PAGE;
    g_col  = gnt1 ? REQ1_COL  : REQ0_COL;
    g_dat  = gnt1 ? REQ1_DATA : REQ0_DATA;
    chip   = g_col[6];
    need_pg  = !ADDR_CACHE || !c_vld[chip] || (c_pg[chip]  != g_pg);
    need_col = !ADDR_CACHE || !c_vld[chip] || (c_col[chip] != g_col[5:0]);
  end

  always_ff @(posedge LCD_CLK or negedge RESETN)
    if (!RESETN) state <= INIT_ON;
    else         state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      INIT_ON:   state_nxt = INIT_LINE;
      INIT_LINE: state_nxt = IDLE;
      IDLE:      if (accept) state_nxt = need_pg ? SET_PAGE : (need_col ? SET_COL : WRITE);
      SET_PAGE:  state_nxt = ncol_q ? SET_COL : WRITE;
      SET_COL:   state_nxt = WRITE;
      WRITE:     state_nxt = IDLE;
      default:   state_nxt = INIT_ON;
    endcase
  end

  always_comb begin
    REQ0_READY = (state == IDLE) && gnt0;
    REQ1_READY = (state == IDLE) && gnt1;
    accept     = REQ0_READY || REQ1_READY;
    BUSY       = (state == INIT_ON) || (state == INIT_LINE);
    en_d   = 1'b1;
    data_d = LCD_DATA;
    di_d   = 1'b0;
    cs1_d  = ~col_q[6];
    cs2_d  = col_q[6];
    case (state)
      INIT_ON:   begin data_d = 8'h3F; cs1_d = 1'b1; cs2_d = 1'b1; end
      INIT_LINE: begin data_d = {2'b11, START_LINE}; cs1_d = 1'b1; cs2_d = 1'b1; end
      SET_PAGE:  data_d = {5'b10111, pg_q};
      SET_COL:   data_d = {2'b01, col_q[5:0]};
      WRITE:     begin data_d = dat_q; di_d = 1'b1; end
      default:   begin en_d = 1'b0; di_d = LCD_DI; cs1_d = LCD_CS1; cs2_d = LCD_CS2; end
    endcase
  end

  // Bus signals are registered so data/DI/CS hold steady across the enable period.
  always_ff @(posedge LCD_CLK or negedge RESETN)
    if (!RESETN) begin
      LCD_DATA <= 8'h00;
      enable   <= 1'b0;
      LCD_DI   <= 1'b0;
      LCD_CS1  <= 1'b0;
      LCD_CS2  <= 1'b0;
    end else begin
      LCD_DATA <= data_d;
      enable   <= en_d;
      LCD_DI   <= di_d;
      LCD_CS1  <= cs1_d;
      LCD_CS2  <= cs2_d;
    end

  always_ff @(posedge LCD_CLK or negedge RESETN)
    if (!RESETN) begin
      last   <= 1'b0;
      pg_q   <= '0;
      col_q  <= '0;
      dat_q  <= '0;
      ncol_q <= 1'b0;
      c_vld  <= '0;
      c_pg   <= '0;
      c_col  <= '0;
    end else begin
      if (accept) begin
        last   <= gnt1;
        pg_q   <= g_pg;
        col_q  <= g_col;
        dat_q  <= g_dat;
        ncol_q <= need_col;
      end
      case (state)
        SET_PAGE: c_pg[col_q[6]] <= pg_q;
        SET_COL:  begin c_col[col_q[6]] <= col_q[5:0]; c_vld[col_q[6]] <= 1'b1; end
        WRITE:    c_col[col_q[6]] <= col_q[5:0] + 6'd1; // chip auto-increments, 63 wraps to 0
        default:  ;
      endcase
    end

  assign LCD_ENABLE = LCD_CLK & enable;
  assign LCD_RW     = 1'b0;
  assign LCD_RSTN   = RESETN;

endmodule
